// File: rtl/adc_scan_spi.sv
// Multi-channel SPI ADC scanner: pipelined frames with one trailing collect frame, CS_N held low for the whole scan.
// Optional continuous scanning (adds port 'cont') is enabled by defining ADC_SCAN_CONT_EN.
module adc_scan_spi #(
    parameter int CLK_DIV = 11,
    parameter int CH_W    = 3,
    parameter int DATA_W  = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2**CH_W-1:0]   ch_mask,
`ifdef ADC_SCAN_CONT_EN
    input  logic                 cont,
`endif
    output logic                 SCLK,
    output logic                 CS_N,
    output logic                 DIN,
    input  logic                 DOUT,
    output logic                 busy,
    output logic                 data_valid,
    output logic [DATA_W-1:0]    data,
    output logic [CH_W-1:0]      data_ch,
    output logic                 done
);
    localparam int NCH = 2**CH_W;
    localparam logic [3:0] S_LO = 4'd4;
    localparam logic [3:0] S_HI = 4'(3 + DATA_W);

    typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;

    state_t              state_q, state_d;
    logic [7:0]          div_q, div_d;
    logic [4:0]          half_q, half_d;
    logic [NCH-1:0]      mask_q, mask_d, rem_q, rem_d;
    logic [CH_W-1:0]     cur_q, cur_d, prev_q, prev_d;
    logic                first_q, first_d, coll_q, coll_d, pend_q, pend_d;
    logic [DATA_W-1:0]   sh_q, sh_d, data_q, data_d;
    logic [CH_W-1:0]     data_ch_q, data_ch_d;
    logic                sclk_q, sclk_d, cs_n_q, cs_n_d, din_q, din_d;
    logic                busy_q, busy_d, dv_q, dv_d, done_q, done_d;
    logic                tick, start_frame, cont_s;
    logic [CH_W-1:0]     nxt;
    logic [CH_W:0]       lo_rem, lo_mask;

`ifdef ADC_SCAN_CONT_EN
    assign cont_s = cont;
`else
    assign cont_s = 1'b0;
`endif

    // Control word {00, addr[2:0], 11'b0}; p is the SCLK period index within the frame.
    function automatic logic din_bit(input logic [CH_W-1:0] a, input logic [3:0] p);
        logic [15:0] w;
        w = {2'b00, 3'(a), 11'b0};
        return w[4'd15 - p];
    endfunction

    // {found, index} of the lowest set bit.
    function automatic logic [CH_W:0] lowest(input logic [NCH-1:0] m);
        logic [CH_W:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (m[i]) r = {1'b1, CH_W'(i)};
        return r;
    endfunction

    assign tick    = (div_q == 8'(CLK_DIV - 1));
    assign lo_rem  = lowest(rem_q);
    assign lo_mask = lowest(mask_q);

    always_comb begin
        state_d = state_q;   div_d = (state_q == IDLE || tick) ? 8'd0 : div_q + 8'd1;
        half_d = half_q;     mask_d = mask_q;    rem_d = rem_q;
        cur_d = cur_q;       prev_d = prev_q;    first_d = first_q;
        coll_d = coll_q;     pend_d = 1'b0;      sh_d = sh_q;
        data_d = data_q;     data_ch_d = data_ch_q;
        sclk_d = sclk_q;     cs_n_d = cs_n_q;    din_d = din_q;
        busy_d = busy_q;     dv_d = 1'b0;        done_d = 1'b0;
        start_frame = 1'b0;  nxt = '0;

        if (pend_q) begin
            dv_d      = 1'b1;
            data_d    = sh_q;
            data_ch_d = prev_q;
        end

        case (state_q)
            IDLE: if (start && |ch_mask) begin
                state_d = CS_SETUP; busy_d = 1'b1; cs_n_d = 1'b0;
                mask_d  = ch_mask;  rem_d  = ch_mask;
            end
            CS_SETUP: if (tick) begin
                state_d = SHIFT; start_frame = 1'b1;
            end
            SHIFT: if (tick) begin
                if (!half_q[0]) begin
                    sclk_d = 1'b1;
                    half_d = half_q + 5'd1;
                    if (half_q[4:1] >= S_LO && half_q[4:1] <= S_HI)
                        sh_d = {sh_q[DATA_W-2:0], DOUT};
                    if (half_q == 5'd30 && !first_q) pend_d = 1'b1;
                end else if (half_q == 5'd31) begin
                    if (coll_q) state_d = CS_HOLD;
                    else        start_frame = 1'b1;
                end else begin
                    sclk_d = 1'b0;
                    half_d = half_q + 5'd1;
                    din_d  = din_bit(cur_q, half_d[4:1]);
                end
            end
            CS_HOLD: if (tick) begin
                state_d = IDLE; cs_n_d = 1'b1; sclk_d = 1'b1; din_d = 1'b1;
                busy_d  = 1'b0; done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Frame start doubles as its first SCLK falling edge.
        if (start_frame) begin
            sclk_d  = 1'b0;
            half_d  = '0;
            prev_d  = cur_q;
            first_d = (state_q == CS_SETUP);
            if (lo_rem[CH_W]) begin
                nxt = lo_rem[CH_W-1:0];  coll_d = 1'b0;
                rem_d = rem_q & ~({{(NCH-1){1'b0}}, 1'b1} << nxt);
            end else if (cont_s) begin
                nxt = lo_mask[CH_W-1:0]; coll_d = 1'b0;
                rem_d = mask_q & ~({{(NCH-1){1'b0}}, 1'b1} << nxt);
            end else begin
                nxt = '0;                coll_d = 1'b1;
            end
            cur_d = nxt;
            din_d = din_bit(nxt, 4'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;  div_q <= '0;   half_q <= '0;   mask_q <= '0;  rem_q <= '0;
            cur_q <= '0;      prev_q <= '0;  first_q <= 1'b0; coll_q <= 1'b0; pend_q <= 1'b0;
            sh_q <= '0;       data_q <= '0;  data_ch_q <= '0;
            sclk_q <= 1'b1;   cs_n_q <= 1'b1; din_q <= 1'b1;
            busy_q <= 1'b0;   dv_q <= 1'b0;  done_q <= 1'b0;
        end else begin
            state_q <= state_d; div_q <= div_d;   half_q <= half_d; mask_q <= mask_d; rem_q <= rem_d;
            cur_q <= cur_d;     prev_q <= prev_d; first_q <= first_d; coll_q <= coll_d; pend_q <= pend_d;
            sh_q <= sh_d;       data_q <= data_d; data_ch_q <= data_ch_d;
            sclk_q <= sclk_d;   cs_n_q <= cs_n_d; din_q <= din_d;
            busy_q <= busy_d;   dv_q <= dv_d;     done_q <= done_d;
        end
    end

    assign SCLK       = sclk_q;
    assign CS_N       = cs_n_q;
    assign DIN        = din_q;
    assign busy       = busy_q;
    assign data_valid = dv_q;
    assign data       = data_q;
    assign data_ch    = data_ch_q;
    assign done       = done_q;
endmodule

// File: tb/tb_adc_scan_spi.sv
// Directed bench for adc_scan_spi: ADC model answers each frame with the result for the previous frame's channel.
module tb_adc_scan_spi;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, start2 = 1'b0, cont = 1'b0;
    logic [7:0]  ch_mask = '0;
    logic [3:0]  ch_mask2 = '0;
    logic        sclk, cs_n, din, busy, dv, done, dout = 1'b0;
    logic [11:0] data;
    logic [2:0]  data_ch;
    logic        sclk2, cs_n2, din2, busy2, dv2, done2;
    logic [9:0]  data2;
    logic [1:0]  data_ch2;
    int n_chk = 0, n_pass = 0;
    bit mode = 1'b0;

    always #5 clk = ~clk;

    adc_scan_spi dut (.clk(clk), .rst_n(rst_n), .start(start), .ch_mask(ch_mask),
`ifdef ADC_SCAN_CONT_EN
        .cont(cont),
`endif
        .SCLK(sclk), .CS_N(cs_n), .DIN(din), .DOUT(dout), .busy(busy), .data_valid(dv),
        .data(data), .data_ch(data_ch), .done(done));

    adc_scan_spi #(.CLK_DIV(2), .CH_W(2), .DATA_W(10)) dut2 (.clk(clk), .rst_n(rst_n), .start(start2),
        .ch_mask(ch_mask2),
`ifdef ADC_SCAN_CONT_EN
        .cont(1'b0),
`endif
        .SCLK(sclk2), .CS_N(cs_n2), .DIN(din2), .DOUT(1'b1), .busy(busy2), .data_valid(dv2),
        .data(data2), .data_ch(data_ch2), .done(done2));

    // Monitor + ADC model for dut (sole writer of everything below)
    logic [2:0]  addrs[$], dvc[$];
    logic [11:0] dvd[$];
    int done_cnt = 0, done_lat = 0, cs_cyc = 0, cs_falls = 0, idle_err = 0, rc = 0, fc = 0;
    logic [15:0] w = '0;
    logic [2:0]  prev_m = '0;
    logic [11:0] res;
    logic        sp = 1'b1, cp = 1'b1;
    always @(posedge clk) begin
        res = mode ? 12'h100 + {9'b0, prev_m} : 12'hA5C;
        if (cs_n && (!sclk || !din)) idle_err++;
        if (cp && !cs_n) cs_falls++;
        if (cs_n) begin
            if (done) begin done_cnt++; done_lat = cs_cyc; end
            cs_cyc = 0; rc = 0; fc = 0;
        end else begin
            cs_cyc++;
            if (sp && !sclk) begin
                fc++;
                dout <= (fc >= 5 && fc <= 16) ? res[16-fc] : 1'b0;
            end
            if (!sp && sclk) begin
                w = {w[14:0], din}; rc++;
                if (rc == 16) begin addrs.push_back(w[13:11]); prev_m = w[13:11]; rc = 0; fc = 0; end
            end
        end
        if (dv) begin dvd.push_back(data); dvc.push_back(data_ch); end
        sp = sclk; cp = cs_n;
    end

    // Monitor for dut2
    logic [15:0] w2 = '0, w2q[$];
    logic [9:0]  dv2d[$];
    logic [1:0]  dv2c[$];
    int rc2 = 0, done2_cnt = 0;
    logic sp2 = 1'b1;
    always @(posedge clk) begin
        if (cs_n2) rc2 = 0;
        else if (!sp2 && sclk2) begin
            w2 = {w2[14:0], din2}; rc2++;
            if (rc2 == 16) begin w2q.push_back(w2); rc2 = 0; end
        end
        if (dv2) begin dv2d.push_back(data2); dv2c.push_back(data_ch2); end
        if (done2) done2_cnt++;
        sp2 = sclk2;
    end

    task automatic pulse_start(input logic [7:0] m);
        @(negedge clk); ch_mask = m; start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            @(negedge clk);
            if (done_cnt > base) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (cs_n !== 1'b1 || sclk !== 1'b1 || din !== 1'b1) $display("FAIL rst_pins got cs_n=%b sclk=%b din=%b want 1 1 1", cs_n, sclk, din); else n_pass++;
        n_chk++; if (busy !== 1'b0 || dv !== 1'b0 || done !== 1'b0) $display("FAIL rst_flags got busy=%b dv=%b done=%b want 0 0 0", busy, dv, done); else n_pass++;
        n_chk++; if (data !== 12'h000 || data_ch !== 3'd0) $display("FAIL rst_data got %h/%0d want 000/0", data, data_ch); else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        int ab = addrs.size(), db = dvd.size(), dc = done_cnt, cf = cs_falls;
        bit ok;
        mode = 1'b0;
        pulse_start(8'h01);
        n_chk++; if (busy !== 1'b1 || cs_n !== 1'b0) $display("FAIL single_busy got busy=%b cs_n=%b want 1 0", busy, cs_n); else n_pass++;
        wait_done(dc, ok);
        n_chk++; if (!ok) $display("FAIL single_timeout got no done want done"); else n_pass++;
        @(negedge clk);
        n_chk++; if (done_lat !== 726) $display("FAIL single_done_lat got %0d want 726", done_lat); else n_pass++;
        n_chk++; if (addrs.size() - ab !== 2 || addrs[ab] !== 3'd0 || addrs[ab+1] !== 3'd0) $display("FAIL single_frames got %0d frames want 2 at addr 0", addrs.size() - ab); else n_pass++;
        n_chk++; if (dvd.size() - db !== 1) $display("FAIL single_dv_count got %0d want 1", dvd.size() - db);
        else if (dvd[db] !== 12'hA5C || dvc[db] !== 3'd0) $display("FAIL single_data got %h/%0d want a5c/0", dvd[db], dvc[db]); else n_pass++;
        n_chk++; if (busy !== 1'b0 || cs_falls - cf !== 1) $display("FAIL single_end got busy=%b cs_falls=%0d want 0 1", busy, cs_falls - cf); else n_pass++;
        n_chk++; if (data !== 12'hA5C) $display("FAIL single_hold got %h want a5c", data); else n_pass++;
    endtask

    task automatic test_multi;
        int ab = addrs.size(), db = dvd.size(), dc = done_cnt;
        int ea[4] = '{2, 5, 7, 0};
        logic [11:0] ed[3] = '{12'h102, 12'h105, 12'h107};
        int ec[3] = '{2, 5, 7};
        bit ok;
        mode = 1'b1;
        pulse_start(8'b1010_0100);
        wait_done(dc, ok);
        n_chk++; if (!ok) $display("FAIL multi_timeout got no done want done"); else n_pass++;
        n_chk++; if (addrs.size() - ab !== 4) $display("FAIL multi_frames got %0d want 4", addrs.size() - ab); else n_pass++;
        for (int i = 0; i < 4 && ab + i < addrs.size(); i++) begin
            n_chk++; if (addrs[ab+i] !== 3'(ea[i])) $display("FAIL multi_addr%0d got %0d want %0d", i, addrs[ab+i], ea[i]); else n_pass++;
        end
        n_chk++; if (dvd.size() - db !== 3) $display("FAIL multi_dv_count got %0d want 3", dvd.size() - db); else n_pass++;
        for (int i = 0; i < 3 && db + i < dvd.size(); i++) begin
            n_chk++; if (dvd[db+i] !== ed[i] || dvc[db+i] !== 3'(ec[i])) $display("FAIL multi_dv%0d got %h/%0d want %h/%0d", i, dvd[db+i], dvc[db+i], ed[i], ec[i]); else n_pass++;
        end
    endtask

    task automatic test_ignore;
        int ab, dc, cf = cs_falls;
        bit ok;
        pulse_start(8'h00);
        repeat (40) @(negedge clk);
        n_chk++; if (busy !== 1'b0 || cs_n !== 1'b1 || cs_falls !== cf) $display("FAIL ign_zero got busy=%b cs_n=%b falls=%0d want 0 1 %0d", busy, cs_n, cs_falls, cf); else n_pass++;
        ab = addrs.size(); dc = done_cnt;
        pulse_start(8'h01);
        repeat (100) @(negedge clk);
        pulse_start(8'hFF);
        n_chk++; if (busy !== 1'b1) $display("FAIL ign_busy got %b want 1", busy); else n_pass++;
        wait_done(dc, ok);
        repeat (50) @(negedge clk);
        n_chk++; if (!ok || addrs.size() - ab !== 2 || done_cnt - dc !== 1 || cs_falls - cf !== 1)
            $display("FAIL ign_busy_scan got frames=%0d done=%0d falls=%0d want 2 1 1", addrs.size() - ab, done_cnt - dc, cs_falls - cf); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int ab = addrs.size(), db, dc;
        bit ok = 1'b0;
        pulse_start(8'hFF);
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            if (addrs.size() - ab >= 6) ok = 1'b1;
        end
        n_chk++; if (!ok) $display("FAIL rmid_timeout got %0d frames want 6", addrs.size() - ab); else n_pass++;
        repeat (60) @(negedge clk);
        db = dvd.size(); dc = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (cs_n !== 1'b1 || sclk !== 1'b1 || busy !== 1'b0) $display("FAIL rmid_async got cs_n=%b sclk=%b busy=%b want 1 1 0", cs_n, sclk, busy); else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        n_chk++; if (dvd.size() !== db || done_cnt !== dc) $display("FAIL rmid_quiet got dv=%0d done=%0d want %0d %0d", dvd.size(), done_cnt, db, dc); else n_pass++;
        ab = addrs.size();
        mode = 1'b1;
        pulse_start(8'h21);
        wait_done(dc, ok);
        n_chk++; if (!ok || addrs.size() - ab !== 3) $display("FAIL rmid_next_frames got %0d want 3", addrs.size() - ab);
        else if (addrs[ab] !== 3'd0 || addrs[ab+1] !== 3'd5 || addrs[ab+2] !== 3'd0) $display("FAIL rmid_next_addr got %0d,%0d,%0d want 0,5,0", addrs[ab], addrs[ab+1], addrs[ab+2]); else n_pass++;
        n_chk++; if (dvd.size() - db !== 2) $display("FAIL rmid_next_dv got %0d want 2", dvd.size() - db);
        else if (dvd[db] !== 12'h100 || dvc[db] !== 3'd0 || dvd[db+1] !== 12'h105 || dvc[db+1] !== 3'd5)
            $display("FAIL rmid_next_data got %h/%0d %h/%0d want 100/0 105/5", dvd[db], dvc[db], dvd[db+1], dvc[db+1]); else n_pass++;
    endtask

`ifdef ADC_SCAN_CONT_EN
    task automatic test_cont;
        int ab = addrs.size(), db = dvd.size(), dc = done_cnt;
        int ea[7] = '{0, 1, 0, 1, 0, 1, 0};
        bit ok = 1'b0;
        mode = 1'b1;
        cont = 1'b1;
        pulse_start(8'h03);
        for (int i = 0; i < 10000 && !ok; i++) begin
            @(negedge clk);
            if (addrs.size() - ab >= 5) ok = 1'b1;
        end
        cont = 1'b0;
        wait_done(dc, ok);
        repeat (20) @(negedge clk);
        n_chk++; if (!ok || addrs.size() - ab !== 7) $display("FAIL cont_frames got %0d want 7", addrs.size() - ab); else n_pass++;
        for (int i = 0; i < 7 && ab + i < addrs.size(); i++) begin
            n_chk++; if (addrs[ab+i] !== 3'(ea[i])) $display("FAIL cont_addr%0d got %0d want %0d", i, addrs[ab+i], ea[i]); else n_pass++;
        end
        n_chk++; if (dvd.size() - db !== 6 || done_cnt - dc !== 1) $display("FAIL cont_counts got dv=%0d done=%0d want 6 1", dvd.size() - db, done_cnt - dc); else n_pass++;
    endtask
`endif

    task automatic test_narrow;
        int wb = w2q.size(), db = dv2d.size(), dc = done2_cnt;
        logic [15:0] ew[3] = '{16'h0800, 16'h1800, 16'h0000};
        bit ok = 1'b0;
        @(negedge clk); ch_mask2 = 4'b1010; start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            if (done2_cnt > dc) ok = 1'b1;
        end
        n_chk++; if (!ok || w2q.size() - wb !== 3) $display("FAIL narrow_frames got %0d want 3", w2q.size() - wb); else n_pass++;
        for (int i = 0; i < 3 && wb + i < w2q.size(); i++) begin
            n_chk++; if (w2q[wb+i] !== ew[i]) $display("FAIL narrow_word%0d got %h want %h", i, w2q[wb+i], ew[i]); else n_pass++;
        end
        n_chk++; if (dv2d.size() - db !== 2) $display("FAIL narrow_dv got %0d want 2", dv2d.size() - db);
        else if (dv2d[db] !== 10'h3FF || dv2c[db] !== 2'd1 || dv2d[db+1] !== 10'h3FF || dv2c[db+1] !== 2'd3)
            $display("FAIL narrow_data got %h/%0d %h/%0d want 3ff/1 3ff/3", dv2d[db], dv2c[db], dv2d[db+1], dv2c[db+1]); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_single;
        test_multi;
        test_ignore;
        test_reset_mid;
`ifdef ADC_SCAN_CONT_EN
        test_cont;
`endif
        test_narrow;
        n_chk++; if (idle_err !== 0) $display("FAIL idle_pins got %0d violations want 0", idle_err); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/adc_scan_spi.md
ADC_SCAN_SPI -- requirements
Module: adc_scan_spi

Interface
REQ-001 SHALL have parameter CLK_DIV, default 11, meaning clk cycles per SCLK half-period, legal range 2..255.
REQ-002 SHALL have parameter CH_W, default 3, meaning channel address width, legal range 1..3.
REQ-003 SHALL have parameter DATA_W, default 12, meaning result bits kept, MSB-first, legal range 8..12.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle scan request.
REQ-007 ch_mask  input  2**CH_W  channels to scan; bit i selects channel i.
REQ-008 cont  input  1  continuous-scan request; this port exists only with ADC_SCAN_CONT_EN.
REQ-009 SCLK  output  1  ADC serial clock; idles high.
REQ-010 CS_N  output  1  ADC chip select, active low.
REQ-011 DIN  output  1  ADC control bit stream.
REQ-012 DOUT  input  1  ADC serial data.
REQ-013 busy  output  1  scan in progress.
REQ-014 data_valid  output  1  one-cycle pulse: new result on data/data_ch.
REQ-015 data  output  DATA_W  latest conversion result.
REQ-016 data_ch  output  CH_W  channel of latest result.
REQ-017 done  output  1  one-cycle pulse at scan end.

Function
REQ-018 SHALL use state machine IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> IDLE.
REQ-019 In IDLE, start=1 with ch_mask!=0 SHALL latch ch_mask, enter CS_SETUP and set busy=1 on the next cycle.
REQ-020 start SHALL be ignored when busy=1 or when ch_mask=0.
REQ-021 CS_SETUP SHALL drive CS_N=0 for one half-period and then enter SHIFT.
REQ-022 Each frame SHALL be 16 SCLK periods, each a falling edge then a rising edge, one half-period apart.
REQ-023 DIN SHALL change only at SCLK falling edges and carry control word {2'b00, addr zero-extended to 3 bits, 11'b0}, MSB first.
REQ-024 DOUT SHALL be sampled at rising edges 5..4+DATA_W of a frame (1-based), MSB first.
REQ-025 Channels SHALL be addressed in ascending index order of set mask bits.
REQ-026 A scan of K set bits SHALL be K+1 back-to-back frames with CS_N held low throughout.
REQ-027 The final (collect) frame SHALL address channel 0.
REQ-028 The result of frame 1 SHALL be discarded.
REQ-029 The result of frame n>=2 SHALL be tagged with the channel addressed in frame n-1.
REQ-030 The cycle after the 16th rising edge of frame n>=2, the block SHALL update data/data_ch and pulse data_valid; data/data_ch SHALL hold until the next pulse.
REQ-031 After the collect frame, CS_HOLD SHALL keep CS_N=0 for one half-period; CS_N SHALL then go high and done SHALL pulse in the same cycle, with busy=0 from that cycle.
REQ-032 SCLK SHALL be high and DIN=1 whenever CS_N=1.
REQ-033 ch_mask and start changes during a scan SHALL have no effect.

Reset
REQ-034 rst_n=0 SHALL, asynchronously and at any point including mid-frame, force IDLE with SCLK=1, CS_N=1, DIN=1, busy=0, data_valid=0, done=0, data=0, data_ch=0, and clear all counters.
REQ-035 The first scan after reset release SHALL behave identically to any other scan.

Configuration
REQ-036 Macro ADC_SCAN_CONT_EN SHALL control continuous scan.
REQ-037 With ADC_SCAN_CONT_EN defined, cont SHALL be sampled when the collect frame is about to start; if cont=1, that frame SHALL instead address the first mask channel, the scan SHALL continue seamlessly with CS_N low and done not asserted, and the check SHALL repeat at each wrap.
REQ-038 Without ADC_SCAN_CONT_EN, the cont port SHALL be absent and every scan SHALL be single-pass.

Verification
REQ-039 Reset, CLK_DIV=11, mask=8'h01, DOUT model returns 12'hA5C -> frames addr 0 then 0; one data_valid with data=12'hA5C, data_ch=0; done 2*352+22 cycles after CS_N falls.
REQ-040 mask=8'b1010_0100, model returns 12'h100+ch -> data_valid x3: (12'h102,2), (12'h105,5), (12'h107,7); DIN addresses 2,5,7,0.
REQ-041 start pulsed while busy, and start with mask=0 in IDLE -> no extra frames, no CS_N activity, busy unchanged.
REQ-042 rst_n low mid-frame 7 of a scan -> CS_N=1, SCLK=1 immediately; no data_valid/done; next scan correct.
REQ-043 ADC_SCAN_CONT_EN, mask=8'h03, cont=1 for 3 passes then 0 -> addresses 0,1,0,1,0,1,0; 6 data_valid; one done at end.
REQ-044 CH_W=2, DATA_W=10, model 12'hFFF -> data=10'h3FF; DIN addr bits 0_xx; 4-bit ch_mask honoured.
